// File: rtl/vpu_pkg.sv
// Shared types and defaults for the VPU systolic MAC array.
package vpu_pkg;

    // Control states of the systolic array job sequencer.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4
    } mac_state_e;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ACC_WIDTH  = 32;

    // Steps of zero injection needed for the last skewed product to reach
    // the far corner PE of a rows x cols grid.
    function automatic int flush_cycles(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One output-stationary MAC processing element: operands pass through
// with one step of latency while the product accumulates locally.
module mac_pe
    import vpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  step,
    input  logic                  signed_en,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic signed [DATA_WIDTH-1:0]   a_sg_s;
    logic signed [DATA_WIDTH-1:0]   b_sg_s;
    logic signed [2*DATA_WIDTH-1:0] prod_signed_s;
    logic [2*DATA_WIDTH-1:0]        prod_unsigned_s;
    logic [ACC_WIDTH-1:0]           prod_ext_s;
    logic [DATA_WIDTH-1:0]          a_r;
    logic [DATA_WIDTH-1:0]          b_r;
    logic [ACC_WIDTH-1:0]           acc_r;

    assign a_sg_s          = a_in;
    assign b_sg_s          = b_in;
    assign prod_signed_s   = a_sg_s * b_sg_s;
    assign prod_unsigned_s = a_in * b_in;

    // Extend the full-width product to the accumulator, sign- or zero-filled.
    always_comb begin
        prod_ext_s = '0;
        if (signed_en) begin
            prod_ext_s = ACC_WIDTH'(prod_signed_s);
        end else begin
            prod_ext_s = ACC_WIDTH'(prod_unsigned_s);
        end
    end

    // Operand pass-through registers and wrapping accumulator, frozen on stall.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
        end else if (step) begin
            a_r   <= a_in;
            b_r   <= b_in;
            acc_r <= acc_r + prod_ext_s;
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            acc_r <= acc_r;
        end
    end

    assign a_out = a_r;
    assign b_out = b_r;
    assign acc   = acc_r;

endmodule

// File: rtl/systolic_mac_array.sv
// ROWS x COLS output-stationary systolic MAC grid computing C = A*B with
// stall-aware input skew, a job sequencer and a row-by-row result drain.
module systolic_mac_array
    import vpu_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int K_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_WIDTH-1:0]         k_len,
    input  logic                       signed_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_a,
    input  logic [COLS*DATA_WIDTH-1:0] in_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(ROWS)-1:0]    res_row,
    output logic [COLS*ACC_WIDTH-1:0]  res_data,
    output logic                       busy,
    output logic                       done
);

    localparam int FLUSH_LEN = flush_cycles(ROWS, COLS);
    localparam int FLUSH_W   = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    mac_state_e             state_r;
    mac_state_e             next_s;
    logic [K_WIDTH-1:0]     k_len_r;
    logic                   signed_r;
    logic [K_WIDTH-1:0]     beat_cnt_r;
    logic [FLUSH_W-1:0]     flush_cnt_r;
    logic [ROW_W-1:0]       row_r;
    logic                   in_ready_r;
    logic                   res_valid_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   feed_step_s;
    logic                   step_s;
    logic                   clr_s;
    logic                   row_hs_s;
    logic [COLS*ACC_WIDTH-1:0] res_data_s;

    logic [DATA_WIDTH-1:0]  a_inj_s  [ROWS];
    logic [DATA_WIDTH-1:0]  b_inj_s  [COLS];
    logic [DATA_WIDTH-1:0]  a_edge_s [ROWS];
    logic [DATA_WIDTH-1:0]  b_edge_s [COLS];
    logic [DATA_WIDTH-1:0]  a_bus_s  [ROWS][COLS];
    logic [DATA_WIDTH-1:0]  b_bus_s  [ROWS][COLS];
    logic [ACC_WIDTH-1:0]   acc_s    [ROWS][COLS];

    assign feed_step_s = (state_r == FEED) && in_valid && in_ready_r;
    assign step_s      = feed_step_s || (state_r == FLUSH);
    assign clr_s       = (state_r == CLEAR);
    assign row_hs_s    = (state_r == DRAIN) && res_valid_r && res_ready;

    // Next-state decode for the job sequence IDLE-CLEAR-FEED-FLUSH-DRAIN.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = CLEAR;
                end else begin
                    next_s = IDLE;
                end
            end
            CLEAR: begin
                if (k_len_r == {K_WIDTH{1'b0}}) begin
                    next_s = DRAIN;
                end else begin
                    next_s = FEED;
                end
            end
            FEED: begin
                if (feed_step_s && (beat_cnt_r == (k_len_r - K_WIDTH'(1)))) begin
                    next_s = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
                end else begin
                    next_s = FEED;
                end
            end
            FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) begin
                    next_s = DRAIN;
                end else begin
                    next_s = FLUSH;
                end
            end
            DRAIN: begin
                if (row_hs_s && (row_r == ROW_LAST)) begin
                    next_s = IDLE;
                end else begin
                    next_s = DRAIN;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State register and status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_s;
            in_ready_r  <= (next_s == FEED);
            res_valid_r <= (next_s == DRAIN);
            busy_r      <= (next_s != IDLE);
            done_r      <= (state_r == DRAIN) && (next_s == IDLE);
        end
    end

    // Job configuration captured only when a job is launched from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_len_r  <= '0;
            signed_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            k_len_r  <= k_len;
            signed_r <= signed_en;
        end else begin
            k_len_r  <= k_len_r;
            signed_r <= signed_r;
        end
    end

    // Beat, flush and drain-row counters, all rearmed by CLEAR.
    always_ff @(posedge clk) begin
        if (rst || clr_s) begin
            beat_cnt_r  <= '0;
            flush_cnt_r <= '0;
            row_r       <= '0;
        end else begin
            if (feed_step_s) begin
                beat_cnt_r <= beat_cnt_r + K_WIDTH'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (state_r == FLUSH) begin
                flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
            if (row_hs_s) begin
                row_r <= (row_r == ROW_LAST) ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
            end else begin
                row_r <= row_r;
            end
        end
    end

    // Operands entering the skew lines: live data while feeding, zeros otherwise.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            if (state_r == FEED) begin
                a_inj_s[i] = in_a[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                a_inj_s[i] = '0;
            end
        end
        for (int j = 0; j < COLS; j++) begin
            if (state_r == FEED) begin
                b_inj_s[j] = in_b[j*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                b_inj_s[j] = '0;
            end
        end
    end

    // Row i of A is delayed i grid steps before entering PE(i,0).
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew_a
        if (gi == 0) begin : g_direct
            assign a_edge_s[gi] = a_inj_s[gi];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] pipe_r [gi];
            // Stall-aware delay line for this A row.
            always_ff @(posedge clk) begin
                if (rst || clr_s) begin
                    for (int k = 0; k < gi; k++) pipe_r[k] <= '0;
                end else if (step_s) begin
                    pipe_r[0] <= a_inj_s[gi];
                    for (int k = 1; k < gi; k++) pipe_r[k] <= pipe_r[k-1];
                end else begin
                    for (int k = 0; k < gi; k++) pipe_r[k] <= pipe_r[k];
                end
            end
            assign a_edge_s[gi] = pipe_r[gi-1];
        end
    end

    // Column j of B is delayed j grid steps before entering PE(0,j).
    for (genvar gj = 0; gj < COLS; gj++) begin : g_skew_b
        if (gj == 0) begin : g_direct
            assign b_edge_s[gj] = b_inj_s[gj];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] pipe_r [gj];
            // Stall-aware delay line for this B column.
            always_ff @(posedge clk) begin
                if (rst || clr_s) begin
                    for (int k = 0; k < gj; k++) pipe_r[k] <= '0;
                end else if (step_s) begin
                    pipe_r[0] <= b_inj_s[gj];
                    for (int k = 1; k < gj; k++) pipe_r[k] <= pipe_r[k-1];
                end else begin
                    for (int k = 0; k < gj; k++) pipe_r[k] <= pipe_r[k];
                end
            end
            assign b_edge_s[gj] = pipe_r[gj-1];
        end
    end

    // PE grid: A flows right along rows, B flows down along columns.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic [DATA_WIDTH-1:0] a_src_s;
            logic [DATA_WIDTH-1:0] b_src_s;
            if (gj == 0) begin : g_a_edge
                assign a_src_s = a_edge_s[gi];
            end else begin : g_a_chain
                assign a_src_s = a_bus_s[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_src_s = b_edge_s[gj];
            end else begin : g_b_chain
                assign b_src_s = b_bus_s[gi-1][gj];
            end
            mac_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk       (clk),
                .rst       (rst),
                .clr       (clr_s),
                .step      (step_s),
                .signed_en (signed_r),
                .a_in      (a_src_s),
                .b_in      (b_src_s),
                .a_out     (a_bus_s[gi][gj]),
                .b_out     (b_bus_s[gi][gj]),
                .acc       (acc_s[gi][gj])
            );
        end
    end

    // Result row mux; accumulators hold during DRAIN so the row stays stable.
    always_comb begin
        res_data_s = '0;
        for (int j = 0; j < COLS; j++) begin
            res_data_s[j*ACC_WIDTH +: ACC_WIDTH] = acc_s[row_r][j];
        end
    end

    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign res_row   = row_r;
    assign res_data  = res_data_s;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
